// File: rtl/sub_borrow_ahead_seq_if.sv
// ---------------------------------------------------------------------------
// sub_borrow_ahead_seq_if
//
// Bundles the operand-in and result-out handshakes of sub_borrow_ahead_seq.
//
//   in_valid_i / in_ready_o   operand set handshake
//   a_i, b_i, bin_i           minuend, subtrahend, borrow in
//   out_valid_o / out_ready_i result handshake
//   diff_o                    a - b - bin modulo 2^WIDTH
//   borrow_o                  unsigned borrow out
//   ovf_o                     two's-complement overflow
//   zero_o                    diff_o == 0
//
// master: the producer/consumer driving operands and taking results.
// slave : the subtractor itself.
// ---------------------------------------------------------------------------
interface sub_borrow_ahead_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] diff_o;
    logic             borrow_o;
    logic             ovf_o;
    logic             zero_o;

    modport master (
        output in_valid_i, a_i, b_i, bin_i, out_ready_i,
        input  in_ready_o, out_valid_o, diff_o, borrow_o, ovf_o, zero_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, bin_i, out_ready_i,
        output in_ready_o, out_valid_o, diff_o, borrow_o, ovf_o, zero_o
    );
endinterface

// File: rtl/sub_borrow_ahead_seq.sv
// ---------------------------------------------------------------------------
// sub_borrow_ahead_seq
//
// Sequential subtractor: computes a - b - bin one 4-bit nibble per cycle,
// LSB first, using a flat 4-bit borrow lookahead inside each nibble and a
// registered running borrow between nibbles.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      sub_borrow_ahead_seq_if.slave (operand/result handshakes)
//
// Timing: the accept edge loads the operands; the next WIDTH/4 edges each
// process one nibble; the last of those moves to DONE, where the result is
// held with out_valid_o = 1 until the consumer takes it.
// ---------------------------------------------------------------------------
module sub_borrow_ahead_seq #(
    parameter int WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    sub_borrow_ahead_seq_if.slave bus
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int CNT_W   = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;

    // Operands shift right one nibble per RUN cycle, so the nibble being
    // processed is always in bits [3:0]; the sign bits are kept separately
    // for the overflow term.
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [CNT_W-1:0] nib_cnt_q;
    logic             ovf_q, zero_q;

    logic             accept;
    logic             last_nib;

    // Nibble lookahead signals
    logic [3:0]       a_n, b_n, g, p, bint;
    logic             grp_g, grp_p, nib_bout;
    logic [3:0]       d_nib;
    logic [WIDTH-1:0] diff_next;

    assign accept   = bus.in_valid_i && (state_q == IDLE);
    assign last_nib = (state_q == RUN) && (nib_cnt_q == LAST_NIB);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples the pre-edge values of its inputs.
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d         = state_q;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) state_d = RUN;
            end
            RUN: begin
                if (nib_cnt_q == LAST_NIB) state_d = DONE;
            end
            DONE: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Flat 4-bit borrow lookahead for the current nibble.
    // A bit generates a borrow when a=0,b=1 and propagates an incoming
    // borrow when a=0 or b=1. Each internal borrow is a two-level sum of
    // products of g, p and the running borrow, with no ripple.
    // -----------------------------------------------------------------------
    always_comb begin
        a_n = a_sh_q[3:0];
        b_n = b_sh_q[3:0];
        g   = ~a_n & b_n;
        p   = ~a_n | b_n;

        bint[0] = borrow_q;
        bint[1] = g[0]
                | (p[0] & borrow_q);
        bint[2] = g[1]
                | (p[1] & g[0])
                | (p[1] & p[0] & borrow_q);
        bint[3] = g[2]
                | (p[2] & g[1])
                | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & borrow_q);

        grp_g    = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
        grp_p    = &p;
        nib_bout = grp_g | (grp_p & borrow_q);

        d_nib     = a_n ^ b_n ^ bint;
        // Result nibbles enter at the top and shift down, so after the last
        // nibble the full difference sits in place.
        diff_next = {d_nib, diff_q[WIDTH-1:4]};
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            a_msb_q   <= 1'b0;
            b_msb_q   <= 1'b0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            nib_cnt_q <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (accept) begin
            a_sh_q    <= bus.a_i;
            b_sh_q    <= bus.b_i;
            a_msb_q   <= bus.a_i[WIDTH-1];
            b_msb_q   <= bus.b_i[WIDTH-1];
            diff_q    <= '0;
            borrow_q  <= bus.bin_i;
            nib_cnt_q <= '0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
        end else if (state_q == RUN) begin
            a_sh_q   <= a_sh_q >> 4;
            b_sh_q   <= b_sh_q >> 4;
            diff_q   <= diff_next;
            borrow_q <= nib_bout;
            // The counter stops on the last nibble instead of wrapping.
            if (!last_nib) nib_cnt_q <= nib_cnt_q + 1'b1;
            if (last_nib) begin
                // d_nib[3] is the sign bit of the final difference.
                ovf_q  <= (a_msb_q ^ b_msb_q) & (d_nib[3] ^ a_msb_q);
                zero_q <= (diff_next == '0);
            end
        end
    end

    assign bus.diff_o   = diff_q;
    assign bus.borrow_o = borrow_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_sub_borrow_ahead_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_borrow_ahead_seq
//
// Self-checking bench for sub_borrow_ahead_seq (WIDTH = 32): directed vector
// table, randomized operations with input noise against an arithmetic
// reference model, back-pressure and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_sub_borrow_ahead_seq;

    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    sub_borrow_ahead_seq_if #(.WIDTH(WIDTH)) bus ();

    sub_borrow_ahead_seq #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic, unsigned and signed.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic bin, output logic [31:0] diff,
                                  output logic borrow, output logic ovf,
                                  output logic zero);
        longint ua, ub, lb, ud, sa, sb, sd;
        ua = longint'(a);
        ub = longint'(b);
        lb = longint'(bin);
        ud = ua - ub - lb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb - lb;
        diff   = 32'(ud);
        borrow = (ud < 0);
        ovf    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        zero   = (diff == 32'h0);
    endfunction

    task automatic check_result(input string tag, input logic [31:0] ed,
                                input logic eb, input logic eo, input logic ez);
        check({tag, " diff"},   bus.diff_o,   ed);
        check({tag, " borrow"}, bus.borrow_o, eb);
        check({tag, " ovf"},    bus.ovf_o,    eo);
        check({tag, " zero"},   bus.zero_o,   ez);
    endtask

    // Called right after an accepting rising edge. Waits (bounded) for
    // out_valid, checks latency and result, optionally completes the
    // handshake. With noise set, in_valid/operands/out_ready toggle randomly
    // while the operation is in flight.
    task automatic finish_op(input string tag, input logic [31:0] ed,
                             input logic eb, input logic eo, input logic ez,
                             input bit noise, input bit handshake);
        int cyc;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        cyc = 0;
        while (!bus.out_valid_o && cyc < 50) begin
            if (noise) begin
                bus.in_valid_i  = 1'($urandom);
                bus.a_i         = $urandom;
                bus.b_i         = $urandom;
                bus.bin_i       = 1'($urandom);
                bus.out_ready_i = 1'($urandom);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        check({tag, " latency"}, cyc, LAT);
        check_result(tag, ed, eb, eo, ez);
        if (handshake) begin
            bus.out_ready_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.out_ready_i = 1'b0;
            check({tag, " post out_valid"}, bus.out_valid_o, 1'b0);
            check({tag, " post in_ready"},  bus.in_ready_o,  1'b1);
        end
    endtask

    task automatic start_op(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input logic bin);
        int cyc;
        @(negedge clk);
        cyc = 0;
        while (!bus.in_ready_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " in_ready"}, bus.in_ready_o, 1'b1);
        bus.in_valid_i = 1'b1;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.bin_i      = bin;
        @(posedge clk);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic bin, input bit noise);
        logic [31:0] ed;
        logic        eb, eo, ez;
        model(a, b, bin, ed, eb, eo, ez);
        start_op(tag, a, b, bin);
        finish_op(tag, ed, eb, eo, ez, noise, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " in_ready"},  bus.in_ready_o,  1'b1);
        check({tag, " out_valid"}, bus.out_valid_o, 1'b0);
        check_result(tag, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ed, ed2, ra, rb;
        logic        eb, eo, ez, eb2, eo2, ez2, rbin;
        int          seen;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h00001234, 32'h00001234, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h00001234, 32'h00001234, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h80000000, 32'h00000000, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};

        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.bin_i       = 1'b0;
        bus.out_ready_i = 1'b0;

        // Reset state, then release with an operand set already presented:
        // the first rising edge after release must accept it.
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n          = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.a_i        = vecs[0].a;
        bus.b_i        = vecs[0].b;
        bus.bin_i      = vecs[0].bin;
        @(posedge clk);
        finish_op("first_after_reset", vecs[0].diff, vecs[0].borrow,
                  vecs[0].ovf, vecs[0].zero, 1'b0, 1'b1);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            start_op(tag, vecs[i].a, vecs[i].b, vecs[i].bin);
            finish_op(tag, vecs[i].diff, vecs[i].borrow, vecs[i].ovf,
                      vecs[i].zero, 1'b0, 1'b1);
        end

        // Randomized operations with noise on ignored inputs
        for (int i = 0; i < 40; i++) begin
            ra   = $urandom;
            rb   = (i % 8 == 0) ? ra : $urandom;
            rbin = 1'($urandom);
            run_op($sformatf("rand%0d", i), ra, rb, rbin, 1'b1);
        end

        // Back-pressure: result held 5 cycles while new operands wait
        model(32'h12345678, 32'h0F0F0F0F, 1'b1, ed, eb, eo, ez);
        model(32'h00000010, 32'h00000020, 1'b0, ed2, eb2, eo2, ez2);
        start_op("bp", 32'h12345678, 32'h0F0F0F0F, 1'b1);
        finish_op("bp", ed, eb, eo, ez, 1'b0, 1'b0);
        bus.in_valid_i = 1'b1;
        bus.a_i        = 32'h00000010;
        bus.b_i        = 32'h00000020;
        bus.bin_i      = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp hold%0d out_valid", k), bus.out_valid_o, 1'b1);
            check($sformatf("bp hold%0d in_ready", k),  bus.in_ready_o,  1'b0);
            check_result($sformatf("bp hold%0d", k), ed, eb, eo, ez);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        check("bp handshake out_valid", bus.out_valid_o, 1'b0);
        check("bp handshake in_ready",  bus.in_ready_o,  1'b1);
        @(posedge clk);
        finish_op("bp second", ed2, eb2, eo2, ez2, 1'b0, 1'b1);

        // Reset pulse while nibble 3 is in progress
        start_op("rst_mid", 32'hDEADBEEF, 32'h01234567, 1'b0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("rst_mid async");
        repeat (2) @(negedge clk);
        check_reset_values("rst_mid held");
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid_o) seen++;
        end
        check("rst_mid no stale result", seen, 0);
        run_op("after_rst", 32'h00ABCDEF, 32'h00FEDCBA, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends on its own.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
